// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line rate and the
// clocks-per-bit helper, common to the receiver and the matching transmitter.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ = 40_000_000;
    localparam int DEFAULT_UART_BPS = 384000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clocks per bit; callers must keep the result within 4..65535.
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_recv_if.sv
// Receiver-side bundle: serial line in, parallel byte, status flags and the FSM
// state for observation. master = line/consumer side, slave = the receiver.
interface uart_recv_if;
    import uart_pkg::*;

    logic        uart_rxd;
    logic [7:0]  uart_data;
    logic        uart_done;
    logic        frame_err;
    logic        rx_busy;
    uart_state_t state;

    // uart_done is a single-cycle strobe with no back-pressure: the consumer must
    // take uart_data/frame_err in that cycle; they stay held until the next strobe.
    modport master (
        output uart_rxd,
        input  uart_data, uart_done, frame_err, rx_busy, state
    );

    modport slave (
        input  uart_rxd,
        output uart_data, uart_done, frame_err, rx_busy, state
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd pin plus a delayed copy used
// to detect a falling edge on the synchronized line. All flops reset to idle (1).
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic rxd_s1;
    logic rxd_s2;
    logic rxd_s3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= din;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    assign dout = rxd_s2;
    assign fall = rxd_s3 & ~rxd_s2;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first, one mid-bit sample per bit. Returns to IDLE at
// the stop-bit sample so a shortened stop bit from the transmitter is tolerated.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int UART_BPS = DEFAULT_UART_BPS
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    uart_recv_if.slave  bus
);

    localparam int          BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2);

    logic        rxd_s2;
    logic        fall;
    uart_state_t state;
    uart_state_t state_next;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  data_q;
    logic        err_q;
    logic        done_q;
    logic        wrap;
    logic        sample;

    uart_rx_sync u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .din     (bus.uart_rxd),
        .dout    (rxd_s2),
        .fall    (fall)
    );

    assign wrap   = (clk_cnt == CNT_MAX);
    assign sample = (clk_cnt == CNT_MID);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fall) state_next = START;
            START: begin
                if (sample && rxd_s2) state_next = IDLE;
                else if (wrap)        state_next = DATA;
            end
            DATA:  if (wrap && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (sample) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts at 0 on every entry to a new frame or a return to IDLE.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (state != IDLE && state_next != IDLE && !wrap) clk_cnt <= clk_cnt + 16'd1;
            else                                              clk_cnt <= '0;

            if (state == START && state_next == DATA)             bit_cnt <= '0;
            else if (state == DATA && wrap && bit_cnt != 3'd7)    bit_cnt <= bit_cnt + 3'd1;

            if (state == DATA && sample) shift_reg[bit_cnt] <= rxd_s2;

            done_q <= (state == STOP) && sample;
            if (state == STOP && sample) begin
                data_q <= shift_reg;
                err_q  <= ~rxd_s2;
            end
        end
    end

    always_comb begin
        bus.rx_busy   = (state != IDLE);
        bus.state     = state;
        bus.uart_data = data_q;
        bus.uart_done = done_q;
        bus.frame_err = err_q;
    end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: directed scenarios plus random frames, checked against
// expected bytes derived from the frames the bench itself transmits.
module tb_uart_recv;
    import uart_pkg::*;

    localparam int BPS  = 104;        // 40 MHz / 384000 bps, truncated
    localparam int HALF = BPS / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_recv_if bus();

    uart_recv #(.CLK_FREQ(40_000_000), .UART_BPS(384000)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] last_data = 8'h00;

    // Collect every done strobe as {frame_err, data}; check strobe-level rules.
    always @(negedge clk) begin
        if (rst !== 1'b1 && bus.uart_done === 1'b1) begin
            done_cnt++;
            got_q.push_back({bus.frame_err, bus.uart_data});
            total++;
            if (bus.rx_busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_at_done: rx_busy=%b required 0", bus.rx_busy);
            end
            total++;
            if (prev_done === 1'b1) begin
                bad++;
                $display("FAIL done_width: done high on consecutive cycles, required single pulse");
            end
        end
        prev_done = bus.uart_done;
    end

    task automatic idle_line(input int n);
        bus.uart_rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        bus.uart_rxd = 1'b0;
        repeat (BPS) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.uart_rxd = b[i];
            repeat (BPS) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
        send_bits(b, 8);
        bus.uart_rxd = stop_val;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.uart_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.uart_data); end
        total++; if (bus.uart_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.uart_done); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy); end
        total++; if (bus.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", bus.state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle;
        int seen_done, seen_busy, seen_err, seen_data;
        int base;
        seen_done = 0; seen_busy = 0; seen_err = 0; seen_data = 0;
        base = done_cnt;
        bus.uart_rxd = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.uart_done !== 1'b0) seen_done++;
            if (bus.rx_busy !== 1'b0) seen_busy++;
            if (bus.frame_err !== 1'b0) seen_err++;
            if (bus.uart_data !== 8'h00) seen_data++;
        end
        total++; if (seen_done != 0 || done_cnt != base) begin bad++; $display("FAIL idle_done: %0d cycles with done, want 0", seen_done); end
        total++; if (seen_busy != 0) begin bad++; $display("FAIL idle_busy: %0d cycles busy, want 0", seen_busy); end
        total++; if (seen_err != 0) begin bad++; $display("FAIL idle_err: %0d cycles err, want 0", seen_err); end
        total++; if (seen_data != 0) begin bad++; $display("FAIL idle_data: %0d cycles data!=00, want 0", seen_data); end
    endtask

    task automatic test_single;
        int base;
        bit ok;
        logic [8:0] got, exp;
        got_q.delete(); exp_q.delete();
        base = done_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1, BPS);
        idle_line(200);
        wait_dones(base + 1, 3000, ok);
        total++; if (!ok || done_cnt - base != 1) begin bad++; $display("FAIL single_count: got %0d pulses want 1", done_cnt - base); end
        if (got_q.size() > 0) begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL single_data: got err=%b data=%h want err=%b data=%h", got[8], got[7:0], exp[8], exp[7:0]); end
        end
        last_data = 8'hA5;
    endtask

    task automatic test_glitch;
        int base, busy_cycles;
        base = done_cnt;
        busy_cycles = 0;
        bus.uart_rxd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) busy_cycles++;
        end
        bus.uart_rxd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) busy_cycles++;
        end
        total++; if (busy_cycles != HALF + 1) begin bad++; $display("FAIL glitch_busy_len: got %0d cycles want %0d", busy_cycles, HALF + 1); end
        total++; if (done_cnt != base) begin bad++; $display("FAIL glitch_done: got %0d pulses want 0", done_cnt - base); end
        total++; if (bus.uart_data !== last_data) begin bad++; $display("FAIL glitch_data: got %h want %h", bus.uart_data, last_data); end
    endtask

    task automatic test_frame_err;
        int base;
        bit ok;
        logic [8:0] got, exp;
        got_q.delete(); exp_q.delete();
        base = done_cnt;
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0, BPS);
        idle_line(50);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1, BPS);
        idle_line(100);
        wait_dones(base + 2, 3000, ok);
        total++; if (!ok || done_cnt - base != 2) begin bad++; $display("FAIL ferr_count: got %0d pulses want 2", done_cnt - base); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL ferr_frame: got err=%b data=%h want err=%b data=%h", got[8], got[7:0], exp[8], exp[7:0]); end
        end
        last_data = 8'h81;
    endtask

    task automatic test_back_to_back;
        int base;
        bit ok;
        logic [7:0] bytes [3];
        logic [8:0] got, exp;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        got_q.delete(); exp_q.delete();
        base = done_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, bytes[i]});
            send_frame(bytes[i], 1'b1, BPS - 40);
        end
        idle_line(100);
        wait_dones(base + 3, 3000, ok);
        total++; if (!ok || done_cnt - base != 3) begin bad++; $display("FAIL b2b_count: got %0d pulses want 3", done_cnt - base); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL b2b_frame: got err=%b data=%h want err=%b data=%h", got[8], got[7:0], exp[8], exp[7:0]); end
        end
        last_data = 8'h55;
    endtask

    task automatic test_mid_reset;
        int base;
        bit ok;
        logic [8:0] got;
        got_q.delete();
        base = done_cnt;
        send_bits(8'h12, 4);
        bus.uart_rxd = 1'b1;                  // bit 4 of 0x12
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.uart_data !== 8'h00) begin bad++; $display("FAIL mrst_data: got %h want 00", bus.uart_data); end
        total++; if (bus.uart_done !== 1'b0) begin bad++; $display("FAIL mrst_done: got %b want 0", bus.uart_done); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL mrst_err: got %b want 0", bus.frame_err); end
        total++; if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", bus.rx_busy); end
        total++; if (bus.state !== IDLE) begin bad++; $display("FAIL mrst_state: got %0d want %0d", bus.state, IDLE); end
        rst = 1'b0;
        idle_line(1500);
        total++; if (done_cnt != base) begin bad++; $display("FAIL mrst_no_done: got %0d pulses want 0", done_cnt - base); end
        send_frame(8'h12, 1'b1, BPS);
        idle_line(50);
        wait_dones(base + 1, 3000, ok);
        total++; if (!ok || got_q.size() != 1) begin bad++; $display("FAIL mrst_refr_count: got %0d frames want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            total++; if (got !== {1'b0, 8'h12}) begin bad++; $display("FAIL mrst_refr_data: got err=%b data=%h want err=0 data=12", got[8], got[7:0]); end
        end
        got_q.delete();
        last_data = 8'h12;
    endtask

    task automatic test_random;
        int base, n;
        bit ok;
        logic [7:0] b;
        logic stop_val;
        int stop_len;
        logic [8:0] got, exp;
        got_q.delete(); exp_q.delete();
        base = done_cnt;
        n = 12;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            stop_val = ($urandom_range(0, 3) != 0);
            stop_len = stop_val ? $urandom_range(BPS - 44, BPS) : BPS;
            exp_q.push_back({~stop_val, b});
            send_frame(b, stop_val, stop_len);
            idle_line($urandom_range(3, 40));
        end
        idle_line(100);
        wait_dones(base + n, 5000, ok);
        total++; if (!ok || done_cnt - base != n) begin bad++; $display("FAIL rand_count: got %0d pulses want %0d", done_cnt - base, n); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            got = got_q.pop_front(); exp = exp_q.pop_front();
            total++; if (got !== exp) begin bad++; $display("FAIL rand_frame: got err=%b data=%h want err=%b data=%h", got[8], got[7:0], exp[8], exp[7:0]); end
        end
    endtask

    initial begin
        bus.uart_rxd = 1'b1;
        rst = 1'b1;
        test_reset();
        test_idle();
        test_single();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
